prog_load_ctrl: RTL and testbench

PROG_LOAD_CTRL -- requirements
Module: prog_load_ctrl

---
 rtl/prog_load_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_prog_load_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_load_ctrl.sv
// Program load / run / dump session controller for a pipeline test harness.
// Optional dump phase enabled by defining PROG_LOAD_DUMP_EN.
module prog_load_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [9:0]  imem_len,
    input  logic [8:0]  dmem_len,
    input  logic [8:0]  pc_stop,
    input  logic [8:0]  pc,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        imem_we,
    output logic [8:0]  imem_addr,
    output logic [31:0] imem_data,
    output logic        dmem_we_external,
    output logic        dmem_re_external,
    output logic [7:0]  dmem_addr,
    output logic [31:0] dmem_data,
    input  logic [31:0] dmem_out,
    output logic        reg_re,
    output logic [3:0]  reg_addr,
    input  logic [31:0] reg_out,
    output logic        pipe_en,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE, LOAD_I, LOAD_D, RUN, DUMP_RD, DUMP_OUT, FIN
    } state_e;

    state_e      state_q, state_d;
    logic [9:0]  ilen_q, ilen_d;
    logic [8:0]  dlen_q, dlen_d;
    logic [8:0]  stop_q, stop_d;
    logic [8:0]  pc_q;
    logic [9:0]  cnt_q, cnt_d;
    logic        iwe_q, iwe_d;
    logic        dwe_q, dwe_d;
    logic [8:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [9:0]  ilen_sat;
    logic [8:0]  dlen_sat;
    logic        beat;
    logic        run_en;

    assign ilen_sat = (imem_len > 10'd512) ? 10'd512 : imem_len;
    assign dlen_sat = (dmem_len > 9'd256) ? 9'd256 : dmem_len;
    assign in_ready = (state_q == LOAD_I) || (state_q == LOAD_D);
    assign beat     = in_valid && in_ready;
    // Hold the pipeline off while the final load write is still in flight.
    assign run_en   = (state_q == RUN) && !iwe_q && !dwe_q;

`ifdef PROG_LOAD_DUMP_EN
    logic        rdreg_q, rdreg_d;
    logic        cap_q, cap_d;
    logic [31:0] odata_q, odata_d;
    logic        rd;

    assign rd               = (state_q == DUMP_RD);
    assign dmem_re_external = rd && !rdreg_q;
    assign reg_re           = rd && rdreg_q;
    assign dmem_addr        = dmem_re_external ? cnt_q[7:0] : waddr_q[7:0];
    assign reg_addr         = reg_re ? cnt_q[3:0] : 4'd0;
    assign out_valid        = (state_q == DUMP_OUT) && !cap_q;
    assign out_data         = odata_q;
`else
    logic unused_dump_inputs;

    assign unused_dump_inputs = ^{dmem_out, reg_out, out_ready};
    assign dmem_re_external   = 1'b0;
    assign reg_re             = 1'b0;
    assign dmem_addr          = waddr_q[7:0];
    assign reg_addr           = 4'd0;
    assign out_valid          = 1'b0;
    assign out_data           = 32'd0;
`endif

    always_comb begin
        state_d = state_q;
        ilen_d  = ilen_q;
        dlen_d  = dlen_q;
        stop_d  = stop_q;
        cnt_d   = cnt_q;
        iwe_d   = 1'b0;
        dwe_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
`ifdef PROG_LOAD_DUMP_EN
        rdreg_d = rdreg_q;
        cap_d   = cap_q;
        odata_d = odata_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    ilen_d = ilen_sat;
                    dlen_d = dlen_sat;
                    stop_d = pc_stop;
                    cnt_d  = 10'd0;
                    if (ilen_sat != 10'd0)     state_d = LOAD_I;
                    else if (dlen_sat != 9'd0) state_d = LOAD_D;
                    else                       state_d = RUN;
                end
            end
            LOAD_I: begin
                if (beat) begin
                    iwe_d   = 1'b1;
                    waddr_d = cnt_q[8:0];
                    wdata_d = in_data;
                    if (cnt_q == ilen_q - 10'd1) begin
                        cnt_d   = 10'd0;
                        state_d = (dlen_q != 9'd0) ? LOAD_D : RUN;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
            end
            LOAD_D: begin
                if (beat) begin
                    dwe_d   = 1'b1;
                    waddr_d = cnt_q[8:0];
                    wdata_d = in_data;
                    if (cnt_q == {1'b0, dlen_q} - 10'd1) begin
                        cnt_d   = 10'd0;
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
            end
            RUN: begin
                if (run_en && (pc_q >= stop_q)) begin
                    cnt_d = 10'd0;
`ifdef PROG_LOAD_DUMP_EN
                    rdreg_d = (dlen_q == 9'd0);
                    state_d = DUMP_RD;
`else
                    state_d = FIN;
`endif
                end
            end
`ifdef PROG_LOAD_DUMP_EN
            DUMP_RD: begin
                cap_d   = 1'b1;
                state_d = DUMP_OUT;
            end
            DUMP_OUT: begin
                // First cycle captures the read data; then offer it.
                if (cap_q) begin
                    odata_d = rdreg_q ? reg_out : dmem_out;
                    cap_d   = 1'b0;
                end else if (out_ready) begin
                    state_d = DUMP_RD;
                    if (rdreg_q) begin
                        if (cnt_q == 10'd15) state_d = FIN;
                        else                 cnt_d = cnt_q + 10'd1;
                    end else if (cnt_q == {1'b0, dlen_q} - 10'd1) begin
                        rdreg_d = 1'b1;
                        cnt_d   = 10'd0;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
            end
`endif
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ilen_q  <= 10'd0;
            dlen_q  <= 9'd0;
            stop_q  <= 9'd0;
            pc_q    <= 9'd0;
            cnt_q   <= 10'd0;
            iwe_q   <= 1'b0;
            dwe_q   <= 1'b0;
            waddr_q <= 9'd0;
            wdata_q <= 32'd0;
`ifdef PROG_LOAD_DUMP_EN
            rdreg_q <= 1'b0;
            cap_q   <= 1'b0;
            odata_q <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            ilen_q  <= ilen_d;
            dlen_q  <= dlen_d;
            stop_q  <= stop_d;
            pc_q    <= pc;
            cnt_q   <= cnt_d;
            iwe_q   <= iwe_d;
            dwe_q   <= dwe_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
`ifdef PROG_LOAD_DUMP_EN
            rdreg_q <= rdreg_d;
            cap_q   <= cap_d;
            odata_q <= odata_d;
`endif
        end
    end

    assign imem_we          = iwe_q;
    assign imem_addr        = waddr_q;
    assign imem_data        = wdata_q;
    assign dmem_we_external = dwe_q;
    assign dmem_data        = wdata_q;
    assign pipe_en          = run_en;
    assign busy             = (state_q != IDLE);
    assign done             = (state_q == FIN);

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Directed bench for prog_load_ctrl: vector table plus hand sequences
// for saturation, asynchronous reset and (optionally) the dump phase.
module tb_prog_load_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  imem_len = '0;
    logic [8:0]  dmem_len = '0;
    logic [8:0]  pc_stop = '0;
    logic [8:0]  pc = '0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        imem_we;
    logic [8:0]  imem_addr;
    logic [31:0] imem_data;
    logic        dmem_we_external;
    logic        dmem_re_external;
    logic [7:0]  dmem_addr;
    logic [31:0] dmem_data;
    logic [31:0] dmem_out = '0;
    logic        reg_re;
    logic [3:0]  reg_addr;
    logic [31:0] reg_out = '0;
    logic        pipe_en;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] dm [256];

    always #5 clk = ~clk;

    prog_load_ctrl dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_len(imem_len), .dmem_len(dmem_len),
        .pc_stop(pc_stop), .pc(pc),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_data(imem_data),
        .dmem_we_external(dmem_we_external),
        .dmem_re_external(dmem_re_external),
        .dmem_addr(dmem_addr), .dmem_data(dmem_data), .dmem_out(dmem_out),
        .reg_re(reg_re), .reg_addr(reg_addr), .reg_out(reg_out),
        .pipe_en(pipe_en),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    // Memory / register-file models with one-cycle read latency.
    always @(posedge clk) begin
        if (dmem_we_external) dm[dmem_addr] <= dmem_data;
        if (dmem_re_external) dmem_out <= dm[dmem_addr];
        if (reg_re) reg_out <= 32'hF000_0000 | {28'd0, reg_addr};
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        pc = '0;
    endtask

    typedef struct {
        logic st; logic [9:0] il; logic [8:0] dl; logic [8:0] ps;
        logic iv; logic [31:0] id; logic [8:0] pc;
        logic ir; logic iwe; logic dwe; logic [8:0] a; logic [31:0] d;
        logic pe; logic bz; logic dn;
    } vec_t;

    function automatic vec_t mk(
        logic st, logic [9:0] il, logic [8:0] dl, logic [8:0] ps,
        logic iv, logic [31:0] id, logic [8:0] p,
        logic ir, logic iwe, logic dwe, logic [8:0] a, logic [31:0] d,
        logic pe, logic bz, logic dn);
        vec_t v;
        v.st = st; v.il = il; v.dl = dl; v.ps = ps;
        v.iv = iv; v.id = id; v.pc = p;
        v.ir = ir; v.iwe = iwe; v.dwe = dwe; v.a = a; v.d = d;
        v.pe = pe; v.bz = bz; v.dn = dn;
        return v;
    endfunction

    initial begin
        vec_t tbl[22];
        int ic, dc, bad, ovl, pec, dn, beats;
        bit seen;
        logic [31:0] ev;

        #2 reset = 1'b1;
        #4;
        chk("reset_ctl", {23'd0, in_ready, imem_we, dmem_we_external,
            dmem_re_external, reg_re, pipe_en, out_valid, busy, done}, 32'd0);
        chk("reset_addr", {11'd0, imem_addr, dmem_addr, reg_addr}, 32'd0);
        chk("reset_idata", imem_data, 32'd0);
        chk("reset_ddata", dmem_data, 32'd0);
        chk("reset_odata", out_data, 32'd0);
        tick();
        reset = 1'b0;
        tick();

`ifndef PROG_LOAD_DUMP_EN
        tbl[0]  = mk(1, 3, 0, 48, 1, 'hA, 0,  1, 0, 0, 0, 0,    0, 1, 0);
        tbl[1]  = mk(0, 0, 0, 0,  1, 'hA, 0,  1, 1, 0, 0, 'hA,  0, 1, 0);
        tbl[2]  = mk(0, 0, 0, 0,  1, 'hB, 0,  1, 1, 0, 1, 'hB,  0, 1, 0);
        tbl[3]  = mk(0, 0, 0, 0,  1, 'hC, 0,  0, 1, 0, 2, 'hC,  0, 1, 0);
        tbl[4]  = mk(0, 0, 0, 0,  0, 0,   0,  0, 0, 0, 0, 0,    1, 1, 0);
        tbl[5]  = mk(0, 0, 0, 0,  0, 0,   16, 0, 0, 0, 0, 0,    1, 1, 0);
        tbl[6]  = mk(0, 0, 0, 0,  0, 0,   32, 0, 0, 0, 0, 0,    1, 1, 0);
        tbl[7]  = mk(0, 0, 0, 0,  0, 0,   48, 0, 0, 0, 0, 0,    1, 1, 0);
        tbl[8]  = mk(0, 0, 0, 0,  0, 0,   64, 0, 0, 0, 0, 0,    0, 1, 1);
        tbl[9]  = mk(0, 0, 0, 0,  0, 0,   0,  0, 0, 0, 0, 0,    0, 0, 0);
        tbl[10] = mk(1, 0, 2, 0,  0, 0,   0,  1, 0, 0, 0, 0,    0, 1, 0);
        tbl[11] = mk(0, 0, 0, 0,  1, 'h11, 0, 1, 0, 1, 0, 'h11, 0, 1, 0);
        tbl[12] = mk(0, 0, 0, 0,  0, 0,   0,  1, 0, 0, 0, 0,    0, 1, 0);
        tbl[13] = mk(0, 0, 0, 0,  0, 0,   0,  1, 0, 0, 0, 0,    0, 1, 0);
        tbl[14] = mk(0, 0, 0, 0,  1, 'h22, 0, 0, 0, 1, 1, 'h22, 0, 1, 0);
        tbl[15] = mk(0, 0, 0, 0,  0, 0,   0,  0, 0, 0, 0, 0,    1, 1, 0);
        tbl[16] = mk(0, 0, 0, 0,  0, 0,   0,  0, 0, 0, 0, 0,    0, 1, 1);
        tbl[17] = mk(0, 0, 0, 0,  0, 0,   0,  0, 0, 0, 0, 0,    0, 0, 0);
        tbl[18] = mk(1, 0, 0, 0,  0, 0,   0,  0, 0, 0, 0, 0,    1, 1, 0);
        tbl[19] = mk(1, 5, 0, 0,  0, 0,   0,  0, 0, 0, 0, 0,    0, 1, 1);
        tbl[20] = mk(1, 5, 0, 0,  0, 0,   0,  0, 0, 0, 0, 0,    0, 0, 0);
        tbl[21] = mk(0, 0, 0, 0,  0, 0,   0,  0, 0, 0, 0, 0,    0, 0, 0);

        for (int i = 0; i < 22; i++) begin
            start = tbl[i].st;
            imem_len = tbl[i].il;
            dmem_len = tbl[i].dl;
            pc_stop = tbl[i].ps;
            in_valid = tbl[i].iv;
            in_data = tbl[i].id;
            pc = tbl[i].pc;
            tick();
            chk($sformatf("v%0d_ready", i), in_ready, tbl[i].ir);
            chk($sformatf("v%0d_iwe", i), imem_we, tbl[i].iwe);
            chk($sformatf("v%0d_dwe", i), dmem_we_external, tbl[i].dwe);
            chk($sformatf("v%0d_pe", i), pipe_en, tbl[i].pe);
            chk($sformatf("v%0d_busy", i), busy, tbl[i].bz);
            chk($sformatf("v%0d_done", i), done, tbl[i].dn);
            chk($sformatf("v%0d_oval", i), out_valid, 1'b0);
            if (tbl[i].iwe) begin
                chk($sformatf("v%0d_iaddr", i), imem_addr, tbl[i].a);
                chk($sformatf("v%0d_idata", i), imem_data, tbl[i].d);
            end
            if (tbl[i].dwe) begin
                chk($sformatf("v%0d_daddr", i), dmem_addr, tbl[i].a[7:0]);
                chk($sformatf("v%0d_ddata", i), dmem_data, tbl[i].d);
            end
        end
        start = 1'b0;
`endif

        // Oversized lengths saturate at 512 / 256 writes.
        do_reset();
        out_ready = 1'b1;
        start = 1'b1;
        imem_len = 10'd700;
        dmem_len = 9'd300;
        pc_stop = 9'd0;
        tick();
        start = 1'b0;
        ic = 0; dc = 0; bad = 0; ovl = 0; pec = 0; dn = 0;
        seen = 1'b0;
        for (int j = 0; j < 3000; j++) begin
            in_valid = 1'b1;
            in_data = 32'h1000 + j;
            tick();
            if (imem_we) begin
                if (imem_addr != ic[8:0] || imem_data != 32'h1000 + ic)
                    bad++;
                ic++;
            end
            if (dmem_we_external) begin
                if (dmem_addr != dc[7:0] || dmem_data != 32'h1200 + dc)
                    bad++;
                dc++;
            end
            if ((imem_we && dmem_we_external) ||
                ((imem_we || dmem_we_external) && pipe_en))
                ovl++;
            if (pipe_en) pec++;
            if (done) dn++;
            if (!busy) begin
                seen = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        chk("sat_finished", seen, 1'b1);
        chk("sat_imem_cnt", ic, 512);
        chk("sat_dmem_cnt", dc, 256);
        chk("sat_addr_data", bad, 0);
        chk("sat_overlap", ovl, 0);
        chk("sat_pe_cycles", pec, 1);
        chk("sat_done", dn, 1);

        // Asynchronous reset while running.
        do_reset();
        start = 1'b1;
        imem_len = 10'd1;
        dmem_len = 9'd0;
        pc_stop = 9'd100;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 32'h55;
        tick();
        in_valid = 1'b0;
        tick();
        chk("rst_run_pe", pipe_en, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_pe", pipe_en, 1'b0);
        chk("rst_async_busy", busy, 1'b0);
        chk("rst_async_we", imem_we, 1'b0);
        tick();
        reset = 1'b0;
        start = 1'b1;
        imem_len = 10'd2;
        tick();
        start = 1'b0;
        chk("rst_new_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        in_data = 32'h66;
        tick();
        in_valid = 1'b0;
        chk("rst_new_we", imem_we, 1'b1);
        chk("rst_new_addr", imem_addr, 9'd0);
        chk("rst_new_data", imem_data, 32'h66);

`ifdef PROG_LOAD_DUMP_EN
        do_reset();
        out_ready = 1'b0;
        start = 1'b1;
        imem_len = 10'd0;
        dmem_len = 9'd2;
        pc_stop = 9'd0;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 32'h11;
        tick();
        in_data = 32'h22;
        tick();
        in_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("dump_first_valid", seen, 1'b1);
        chk("dump_first_data", out_data, 32'h11);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("dump_hold_valid", out_valid, 1'b1);
            chk("dump_hold_data", out_data, 32'h11);
        end
        out_ready = 1'b1;
        beats = 0; bad = 0; dn = 0;
        seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (out_valid) begin
                if (beats == 0) ev = 32'h11;
                else if (beats == 1) ev = 32'h22;
                else ev = 32'hF000_0000 + beats - 2;
                if (out_data != ev) bad++;
                beats++;
            end
            if (done) dn++;
            if (!busy) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("dump_finished", seen, 1'b1);
        chk("dump_beats", beats, 18);
        chk("dump_data", bad, 0);
        chk("dump_done", dn, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
